// File: rtl/instr_fetch.sv
// instr_fetch: program counter and fetch sequencer for the single-cycle core.
// IDLE / RUN / HALTED FSM gates execution; CycleCount tracks cycles in RUN.
// Optional macro FETCH_REL_BRANCH_EN: a taken branch adds signed Target to
// ProgCtr instead of loading Target as an absolute address.
module instr_fetch #(
   parameter int unsigned PC_W       = 10,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Halt,
   input  logic             BranchEn,
   input  logic             BranchFlag,
   input  logic [PC_W-1:0]  Target,
   input  logic             Stall,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCount
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } state_t;

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [PC_W-1:0]   branch_dest;
   logic              taken;

   assign taken = BranchEn & BranchFlag;

`ifdef FETCH_REL_BRANCH_EN
   // Two's-complement add at PC_W bits wraps modulo 2^PC_W for either sign.
   assign branch_dest = ProgCtr + Target;
`else
   assign branch_dest = Target;
`endif

   // Next-state, next-PC and next-count selection; everything holds by default.
   always_comb begin
      state_nxt = state;
      pc_nxt    = ProgCtr;
      cnt_nxt   = CycleCount;
      unique case (state)
         IDLE: begin
            pc_nxt = START_PC;
            if (Start) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (CycleCount != '1)
               cnt_nxt = CycleCount + CNT_W'(1);
            if (Halt)
               state_nxt = HALTED;
            else if (Stall)
               pc_nxt = ProgCtr;
            else if (taken)
               pc_nxt = branch_dest;
            else
               pc_nxt = ProgCtr + PC_W'(1);
         end
         HALTED: begin
            if (Start) begin
               state_nxt = RUN;
               pc_nxt    = START_PC;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            pc_nxt    = START_PC;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, program counter and cycle counter registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         ProgCtr    <= START_PC;
         CycleCount <= '0;
      end else begin
         state      <= state_nxt;
         ProgCtr    <= pc_nxt;
         CycleCount <= cnt_nxt;
      end
   end

   assign Running = (state == RUN);
   assign Done    = (state == HALTED);

endmodule
